demux_dispatch_ctrl: RTL and testbench

Sequencing controller for the 1-to-4 demux datapath. It accepts words from a single upstream source over a valid/ready handshake. It holds each word in a one-entry buffer, drives the 2-bit demux select, and releases the word to exactly one of four downstream channels. The destination is either carried with the word (addressed mode) or picked round-robin among ready channels (round-robin mode). It sits between the upstream source and the demux select/enable lines.

---
 rtl/demux_dispatch_ctrl.sv | 109 ++++++++++
 tb/tb_demux_dispatch_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_dispatch_ctrl.sv
// One-entry buffer that steers each word to one of four channels, addressed or round-robin; 1-cycle latency, upstream stalls while a word waits.
// Optional build macro DEMUX_CTRL_CNT_EN adds dlv_cnt, four saturating 8-bit per-channel delivery counters.
module demux_dispatch_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  input  logic              rr_mode,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        sel,
  output logic              busy
`ifdef DEMUX_CTRL_CNT_EN
  ,
  output logic [31:0]       dlv_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_dest;
  logic              r_mode;
  logic [1:0]        r_rr_ptr;
  logic [1:0]        w_rr_sel;
  logic [1:0]        w_idx;
  logic [1:0]        w_sel;
  logic              w_xfer;
  logic              w_cap;

  // Scan from the farthest offset down so the nearest ready channel after rr_ptr wins.
  always_comb begin
    w_rr_sel = r_rr_ptr;
    w_idx    = r_rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_rr_ptr + 2'(i);
      if (out_ready[w_idx]) begin
        w_rr_sel = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel       = 2'd0;
    out_valid   = 4'b0000;
    w_xfer      = 1'b0;
    if (r_state == HOLD) begin
      w_sel     = r_mode ? w_rr_sel : r_dest;
      out_valid = 4'b0001 << w_sel;
      w_xfer    = out_ready[w_sel];
    end
    in_ready = (r_state == IDLE) || w_xfer;
    w_cap    = in_valid && in_ready;
    if (w_cap) begin
      w_state_nxt = HOLD;
    end else if (w_xfer) begin
      w_state_nxt = IDLE;
    end
  end

  assign sel      = w_sel;
  assign busy     = (r_state == HOLD);
  assign out_data = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_data   <= '0;
      r_dest   <= 2'd0;
      r_mode   <= 1'b0;
      r_rr_ptr <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cap) begin
        r_data <= in_data;
        r_dest <= in_dest;
        r_mode <= rr_mode;
      end
      if (w_xfer && r_mode) begin
        r_rr_ptr <= w_sel + 2'd1;
      end
    end
  end

`ifdef DEMUX_CTRL_CNT_EN
  logic [7:0] r_cnt [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        r_cnt[k] <= 8'd0;
      end
    end else if (w_xfer && (r_cnt[w_sel] != 8'hFF)) begin
      r_cnt[w_sel] <= r_cnt[w_sel] + 8'd1;
    end
  end

  assign dlv_cnt = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Scoreboard bench for demux_dispatch_ctrl: directed test-plan sequences plus a randomized phase,
// checked every cycle against a queue-based reference model of the dispatch rules.
module tb_demux_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_dest;
  logic       rr_mode;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic [1:0] sel;
  logic       busy;
`ifdef DEMUX_CTRL_CNT_EN
  logic [31:0] dlv_cnt;
`endif

  demux_dispatch_ctrl #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .rr_mode   (rr_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .busy      (busy)
`ifdef DEMUX_CTRL_CNT_EN
    ,
    .dlv_cnt   (dlv_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] dest;
    logic       mode;
  } word_t;

  word_t mq[$];
  int    m_ptr;
  int    m_cnt[4];
  int    dlv_log[$];
  int    n_pass  = 0;
  int    n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int rr_pick(input int p, input logic [3:0] rdy);
    for (int i = 0; i < 4; i++) begin
      if (rdy[(p + i) % 4]) return (p + i) % 4;
    end
    return p;
  endfunction

  // Monitor / scoreboard: sample at negedge, inputs change only at posedge+1.
  initial begin
    word_t w;
    int    ch;
    logic  xfer;
    logic  exp_rdy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        mq.delete();
        m_ptr = 0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        continue;
      end
      xfer = 1'b0;
      ch   = 0;
      w    = '0;
      chk("busy", 32'(busy), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        w  = mq[0];
        ch = w.mode ? rr_pick(m_ptr, out_ready) : int'(w.dest);
        chk("out_valid", 32'(out_valid), 32'(4'b0001 << ch));
        chk("sel", 32'(sel), 32'(ch));
        chk("out_data", 32'(out_data), 32'(w.data));
        xfer = out_ready[ch];
      end else begin
        chk("out_valid_idle", 32'(out_valid), 32'd0);
      end
      exp_rdy = (mq.size() == 0) || xfer;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
`ifdef DEMUX_CTRL_CNT_EN
      chk("dlv_cnt", dlv_cnt, {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])});
`endif
      if (xfer) begin
        void'(mq.pop_front());
        dlv_log.push_back(ch);
        if (w.mode) m_ptr = (ch + 1) % 4;
        if (m_cnt[ch] < 255) m_cnt[ch]++;
      end
      if (in_valid && exp_rdy) mq.push_back('{data: in_data, dest: in_dest, mode: rr_mode});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] dst, input logic m, output int n);
    logic acc;
    n   = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_dest  = dst;
    rr_mode  = m;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      n++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic chk_log(input string name, input int exp[$]);
    chk({name, "_len"}, 32'(dlv_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < dlv_log.size(); i++) begin
      chk(name, 32'(dlv_log[i]), 32'(exp[i]));
    end
    dlv_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_dest   = 2'd0;
    rr_mode   = 1'b0;
    out_ready = 4'b0000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Addressed mode, all channels ready: one word per cycle.
    out_ready = 4'b1111;
    dlv_log.delete();
    for (int i = 0; i < 4; i++) begin
      send(8'h11 * 8'(i + 1), 2'(i), 1'b0, n);
      chk("addr_accept_cycles", 32'(n), 32'd1);
    end
    idle(2);
    chk_log("addr_order", '{0, 1, 2, 3});

    // Head-of-line block on stalled channel 3.
    out_ready = 4'b0111;
    send(8'h55, 2'd3, 1'b0, n);
    idle(5);
    out_ready = 4'b1111;
    send(8'h66, 2'd0, 1'b0, n);
    chk("hol_same_cycle_accept", 32'(n), 32'd1);
    idle(2);
    chk_log("hol_order", '{3, 0});

    // Round-robin wrap, then sparse-ready pattern from rr_ptr 2.
    for (int i = 0; i < 6; i++) send(8'($urandom), 2'($urandom), 1'b1, n);
    idle(2);
    chk_log("rr_wrap", '{0, 1, 2, 3, 0, 1});
    out_ready = 4'b1010;
    for (int i = 0; i < 3; i++) send(8'($urandom), 2'($urandom), 1'b1, n);
    idle(2);
    chk_log("rr_1010", '{3, 1, 3});

    // Nothing ready: sel parks on rr_ptr until a channel opens.
    out_ready = 4'b1111;
    send(8'h70, 2'd3, 1'b1, n);
    idle(1);
    out_ready = 4'b0000;
    send(8'h77, 2'd3, 1'b1, n);
    idle(3);
    @(negedge clk);
    chk("rr_none_sel", 32'(sel), 32'd1);
    chk("rr_none_valid", 32'(out_valid), 32'h2);
    @(posedge clk);
    #1 out_ready = 4'b0100;
    idle(2);
    out_ready = 4'b1111;
    send(8'h78, 2'd0, 1'b1, n);
    idle(2);
    chk_log("rr_none", '{0, 2, 3});

    // Reset while holding an addressed word to a stalled channel.
    out_ready = 4'b0000;
    send(8'hA5, 2'd2, 1'b0, n);
    idle(2);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 4'b1111;
    dlv_log.delete();
    idle(3);
    chk("rst_a5_dropped", 32'(dlv_log.size()), 32'd0);

`ifdef DEMUX_CTRL_CNT_EN
    for (int i = 0; i < 300; i++) send(8'(i), 2'd1, 1'b0, n);
    idle(2);
    chk("cnt_saturate", dlv_cnt, 32'h0000FF00);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_dest   = 2'($urandom);
      rr_mode   = 1'($urandom);
      out_ready = 4'($urandom);
      idle(1);
    end
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    idle(4);
    chk("final_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
